// File: rtl/decoder24_pkg.sv
// Shared code constants, one-hot word type and the 2-to-4 decode used by the
// streaming decoder.
package decoder24_pkg;

  localparam logic [1:0] CODE_D0 = 2'b00;
  localparam logic [1:0] CODE_D1 = 2'b01;
  localparam logic [1:0] CODE_D2 = 2'b10;
  localparam logic [1:0] CODE_D3 = 2'b11;

  typedef logic [3:0] onehot4_t;

  function automatic onehot4_t decode(input logic [1:0] code);
    onehot4_t oh;
    oh = '0;
    case (code)
      CODE_D0: oh = 4'b0001;
      CODE_D1: oh = 4'b0010;
      CODE_D2: oh = 4'b0100;
      CODE_D3: oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/decoder24_stream_sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and occupancy count.
// Callers guarantee no push when full and no pop when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/decoder24_stream.sv
// Flow-controlled 2-to-4 decoder: FIFO-buffered codes presented as a registered
// one-hot word with valid/ready, global enable and saturating delivery count.
module decoder24_stream
  import decoder24_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   c0,
  input  logic                   c1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   d0,
  output logic                   d1,
  output logic                   d2,
  output logic                   d3,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       cnt
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic       push;
  logic       pop;
  logic       xfer;
  logic       out_valid_q;
  onehot4_t   word_q;
  logic [1:0] fifo_code;

  sync_fifo #(
    .WIDTH(2),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({c1, c0}),
    .rdata (fifo_code),
    .level (level)
  );

  // in_ready looks only at the registered level, so a full FIFO never
  // accepts in the same cycle it pops.
  assign in_ready  = en && (level != LW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign out_valid = en && out_valid_q;
  assign xfer      = out_valid && out_ready;
  assign pop       = en && (level != '0) && (!out_valid_q || out_ready);

  assign {d3, d2, d1, d0} = out_valid ? word_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      word_q      <= '0;
      cnt         <= '0;
    end else if (en) begin
      if (pop) begin
        out_valid_q <= 1'b1;
        word_q      <= decode(fifo_code);
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end
      if (xfer && (cnt != '1)) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder24_stream.sv
// Bench for decoder24_stream: directed scenarios plus random traffic, checked
// cycle by cycle against a queue-based model of the stream behaviour.
module tb_decoder24_stream;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       c0;
  logic       c1;
  logic       out_ready;
  logic       in_ready;
  logic       out_valid;
  logic       d0, d1, d2, d3;
  logic [2:0] level;
  logic [7:0] cnt;

  logic       in_ready2;
  logic       out_valid2;
  logic       e0, e1, e2, e3;
  logic [2:0] level2;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  // Model: queue of buffered codes, one presented slot, uncapped delivery count.
  int fq[$];
  bit m_ov;
  int m_oc;
  int m_cnt;

  decoder24_stream #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .c0(c0), .c1(c1), .out_valid(out_valid), .out_ready(out_ready),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .level(level), .cnt(cnt)
  );

  decoder24_stream #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready2),
    .c0(c0), .c1(c1), .out_valid(out_valid2), .out_ready(out_ready),
    .d0(e0), .d1(e1), .d2(e2), .d3(e3), .level(level2), .cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_ov  = 0;
    m_oc  = 0;
    m_cnt = 0;
  endtask

  // Apply inputs, check outputs before the edge, advance model across the edge.
  task automatic cycle(input bit r, input bit e, input bit iv, input int code, input bit ordy);
    bit exp_ir;
    bit exp_ov;
    int exp_d;
    bit do_push;
    bit do_pop;
    bit do_xfer;
    logic [1:0] cb;
    cb = code[1:0];
    rst = r; en = e; in_valid = iv; c1 = cb[1]; c0 = cb[0]; out_ready = ordy;
    #1;
    exp_ir = e && (fq.size() != DEPTH);
    exp_ov = e && m_ov;
    exp_d  = exp_ov ? (1 << m_oc) : 0;
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, exp_ov);
    check("d3_d0", {d3, d2, d1, d0}, exp_d);
    check("level", level, fq.size());
    check("cnt", cnt, (m_cnt > 255) ? 255 : m_cnt);
    check("cnt_sat", cnt2, (m_cnt > 3) ? 3 : m_cnt);
    check("d3_d0_sat", {e3, e2, e1, e0}, exp_d);
    if (r) begin
      model_reset();
    end else if (e) begin
      do_push = iv && exp_ir;
      do_xfer = m_ov && ordy;
      do_pop  = (fq.size() > 0) && (!m_ov || ordy);
      if (do_pop) begin
        m_oc = fq.pop_front();
        m_ov = 1;
      end else if (do_xfer) begin
        m_ov = 0;
      end
      if (do_push) fq.push_back(int'(cb));
      if (do_xfer) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; c0 = 1'b0; c1 = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Basic decode of all four codes, back to back.
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, i, 1);
    repeat (3) cycle(0, 1, 0, 0, 1);
    check("cnt_after_four", cnt, 4);

    // Fill pipeline while stalled: 4 in FIFO + 1 presented, sixth offer refused.
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, (i + 1) % 4, 0);
    check("level_full", level, DEPTH);
    check("in_ready_full", in_ready, 0);
    repeat (7) cycle(0, 1, 0, 0, 1);
    check("cnt_after_drain", cnt, 9);

    // Output stall with code 10 held, then a single ready pulse.
    cycle(0, 1, 1, 2, 0);
    repeat (4) cycle(0, 1, 0, 0, 0);
    check("stall_d2", {d3, d2, d1, d0}, 4'b0100);
    cycle(0, 1, 0, 0, 1);
    repeat (2) cycle(0, 1, 0, 0, 0);

    // Enable drop with words buffered; held word must reappear afterwards.
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 3 - i, 0);
    repeat (3) cycle(0, 0, 1, 1, 1);
    repeat (5) cycle(0, 1, 0, 0, 1);

    // Reset with a full pipeline; nothing stale may emerge afterwards.
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, i % 4, 0);
    cycle(1, 1, 0, 0, 1);
    repeat (3) cycle(0, 1, 0, 0, 1);

    // Saturation of the narrow counter: five deliveries.
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, i % 4, 1);
    repeat (3) cycle(0, 1, 0, 0, 1);
    check("cnt_sat_final", cnt2, 3);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 2) != 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder24_stream.md
Name: decoder24_stream

Overview:
- Registered, flow-controlled 2-to-4 decoder. It is the receive-side counterpart of the team's 4-to-2 priority-less encoder (inputs a0..a3, enable, code y0/y1).
- Accepts a stream of 2-bit codes, buffers them in a small FIFO, and presents each one as a registered one-hot word on d0..d3 with a valid/ready handshake.
- Sits downstream of the encoder link and feeds one-hot consumers that may stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  global enable; 0 freezes state and masks outputs.
- in_valid  input  1  code word c1:c0 present.
- in_ready  output  1  FIFO can accept a code this cycle.
- c0  input  1  code bit 0 (LSB), corresponds to encoder y0.
- c1  input  1  code bit 1 (MSB), corresponds to encoder y1.
- out_valid  output  1  one-hot word on d0..d3 valid.
- out_ready  input  1  consumer accepts word.
- d0, d1, d2, d3  output  1 each  one-hot decode; corresponds to encoder a0..a3.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- cnt  output  CNT_W  number of words delivered, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FIFO empty, level=0, output register empty (out_valid=0), d0..d3=0, cnt=0. in_ready=1 in the first cycle after reset if en=1. Reset asserted mid-transfer discards all buffered and presented codes; nothing is delivered after the reset edge.
- Decode map, {c1,c0} -> one-hot:
  - 00 -> d0
  - 01 -> d1
  - 10 -> d2
  - 11 -> d3
  - Exactly one of d0..d3 is high whenever out_valid=1. All of d0..d3 are 0 whenever out_valid=0.
- Input side:
  - in_ready = en && (level != DEPTH).
  - Push when in_valid && in_ready.
  - A full FIFO does not accept a push in the same cycle as a pop. in_ready depends only on the registered level.
- Output stage:
  - A single register stage after the FIFO.
  - Load (pop) when en && FIFO non-empty && (!out_valid_q || out_ready).
  - Output transfer occurs when out_valid && out_ready.
  - Transfer with no pop available: out_valid_q clears.
  - Transfer with a pop available: the back-to-back word is loaded and out_valid stays 1. Sustained throughput is 1 word/clk.
  - Latency: code accepted on edge N into an empty pipeline is presented on outputs after edge N+1; minimum 2-cycle in-to-out.
  - Word held stable while out_valid && !out_ready.
- Enable:
  - en=0 freezes the FIFO, output register, level and cnt.
  - While en=0, in_ready=0; out_valid and d0..d3 are masked to 0 combinationally, so no transfer can occur.
  - On return to en=1, the held word reappears unchanged.
- Occupancy: level updates +1 on push, -1 on pop, unchanged on simultaneous push and pop. Pointers wrap modulo DEPTH.
- Counter: cnt increments by 1 on each output transfer and saturates at 2^CNT_W-1 (no wrap).
- Ordering: strict FIFO order; no reordering, duplication or loss.

Decomposition:
- Package decoder24_pkg holds:
  - code constants CODE_D0=2'b00, CODE_D1=2'b01, CODE_D2=2'b10, CODE_D3=2'b11;
  - onehot4_t typedef (4-bit);
  - decode function code -> onehot4_t.
- Sub-module sync_fifo (parameter WIDTH=2, DEPTH), one instance, holding storage, pointers and level.
- Top level holds the handshake, output register, enable masking and counter.

Test Plan:
- Reset, then en=1, push codes 00,01,10,11 with out_ready=1 -> d3..d0 = 0001, 0010, 0100, 1000 on consecutive cycles, first word 2 cycles after first push, cnt=4.
- out_ready=0, push 5 codes with DEPTH=4 -> in_ready drops after 5th accept (4 in FIFO + 1 in output reg), level=4. Release out_ready -> 5 words delivered in order, no loss.
- Output stall: out_valid=1 with code 10 held and out_ready=0 for 3 cycles -> d2 stays 1, cnt unchanged. Single out_ready pulse -> cnt+1.
- en=0 mid-stream with 2 words buffered -> in_ready=0, out_valid=0, d=0000, level and cnt frozen. en=1 -> held word reappears, then the remainder in order.
- rst asserted for one cycle with a full FIFO and out_valid=1 -> next cycle level=0, out_valid=0, cnt=0, d=0000. No stale word emitted afterwards.
- CNT_W=2, deliver 5 words -> cnt reads 1,2,3,3,3 (saturates).
